// File: rtl/rotate_tile_buf.sv
// -----------------------------------------------------------------------------
// rotate_tile_buf
//
// Ping-pong pixel tile buffer for the rotate datapath. The pixel engine writes
// NCH channel pixels per beat into the current write bank. The bus-master side
// gathers NRD pixels per request from the other bank and packs them into one
// write-data word. Banks change owner through a tile-complete (I_WR_LAST) /
// tile-done (I_RD_DONE) handshake, so writer and reader never share a bank.
//
// Ports:
//   I_HCLK      clock
//   I_HRESET_N  synchronous active-low reset
//   I_WR_VALID  write beat valid
//   I_WR_EN     per-channel write enable within a beat       [NCH]
//   I_WR_PIX    channel pixels, channel c at [c*PIX_W +: PIX_W]
//   I_WR_ADDR   channel addresses, channel c at [c*ADDR_W +: ADDR_W]
//   I_WR_LAST   final beat of the tile (qualified by I_WR_VALID)
//   O_WR_READY  current write bank is free
//   I_RD_VALID  read request valid
//   I_RD_ADDR   lane addresses, lane l at [l*ADDR_W +: ADDR_W]
//   I_RD_DONE   reader releases the current read bank
//   O_RD_AVAIL  a complete tile is readable
//   O_RD_VALID  O_WDATA carries a read result this cycle
//   O_WDATA     packed word, lane 0 in the MSBs, lane NRD-1 in the LSBs
// -----------------------------------------------------------------------------
module rotate_tile_buf #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 6,
  parameter int NCH    = 3,
  parameter int NRD    = 4
) (
  input  logic                    I_HCLK,
  input  logic                    I_HRESET_N,
  input  logic                    I_WR_VALID,
  input  logic [NCH-1:0]          I_WR_EN,
  input  logic [NCH*PIX_W-1:0]    I_WR_PIX,
  input  logic [NCH*ADDR_W-1:0]   I_WR_ADDR,
  input  logic                    I_WR_LAST,
  output logic                    O_WR_READY,
  input  logic                    I_RD_VALID,
  input  logic [NRD*ADDR_W-1:0]   I_RD_ADDR,
  input  logic                    I_RD_DONE,
  output logic                    O_RD_AVAIL,
  output logic                    O_RD_VALID,
  output logic [NRD*PIX_W-1:0]    O_WDATA
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage: two banks of DEPTH pixels each.
  logic [PIX_W-1:0] mem [2][DEPTH];

  // Handshake state.
  logic [1:0] full;
  logic [1:0] full_next;
  logic       wr_ptr;
  logic       rd_ptr;

  // Read pipeline.
  logic             s1_valid;
  logic [PIX_W-1:0] s1_pix [NRD];
  logic [NRD*PIX_W-1:0] s1_packed;

  logic wr_accept;
  logic rd_accept;
  logic rd_release;
  logic wr_complete;

  // Status flags come straight from registers: no input-to-output path.
  assign O_WR_READY = !full[wr_ptr];
  assign O_RD_AVAIL = full[rd_ptr];

  assign wr_accept   = I_WR_VALID && O_WR_READY;
  assign wr_complete = wr_accept && I_WR_LAST;
  assign rd_accept   = I_RD_VALID && O_RD_AVAIL;
  assign rd_release  = I_RD_DONE && O_RD_AVAIL;

  // The write bank is never full and the release bank always is, so the two
  // updates below can never target the same flag in one cycle.
  always_comb begin
    full_next = full;
    if (wr_complete) full_next[wr_ptr] = 1'b1;
    if (rd_release)  full_next[rd_ptr] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_complete) wr_ptr <= ~wr_ptr;
      if (rd_release)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: the pixel arrays are deliberately left out of reset; clearing a RAM
  // would force it into flops. Contents are undefined until written.
  // Channels are visited in ascending order, and the last non-blocking write
  // to an address wins, so the highest channel index wins a collision.
  always_ff @(posedge I_HCLK) begin
    if (I_HRESET_N && wr_accept) begin
      for (int c = 0; c < NCH; c++) begin
        if (I_WR_EN[c]) begin
          mem[wr_ptr][I_WR_ADDR[c*ADDR_W +: ADDR_W]] <= I_WR_PIX[c*PIX_W +: PIX_W];
        end
      end
    end
  end

  // Stage 1 data: reads the bank that rd_ptr names before any release or
  // new write at this edge takes effect, so a read issued alongside
  // I_RD_DONE still returns the tile being released.
  always_ff @(posedge I_HCLK) begin
    if (rd_accept) begin
      for (int l = 0; l < NRD; l++) begin
        s1_pix[l] <= mem[rd_ptr][I_RD_ADDR[l*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Lane 0 lands in the most significant pixel slot.
  always_comb begin
    s1_packed = '0;
    for (int l = 0; l < NRD; l++) begin
      s1_packed[(NRD-1-l)*PIX_W +: PIX_W] = s1_pix[l];
    end
  end

  // Pipeline control and stage 2. O_WDATA only updates on a valid result and
  // otherwise holds its last value.
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      s1_valid   <= 1'b0;
      O_RD_VALID <= 1'b0;
      O_WDATA    <= '0;
    end else begin
      s1_valid   <= rd_accept;
      O_RD_VALID <= s1_valid;
      if (s1_valid) O_WDATA <= s1_packed;
    end
  end

  // With both banks full the pointers must have met.
  a_full_ptrs : assert property (@(posedge I_HCLK) disable iff (!I_HRESET_N)
    (full == 2'b11) |-> (wr_ptr == rd_ptr));

endmodule

// File: tb/tb_rotate_tile_buf.sv
// -----------------------------------------------------------------------------
// tb_rotate_tile_buf
//
// Directed bench for rotate_tile_buf with default parameters (8-bit pixels,
// 64-entry banks, 3 write channels, 4 read lanes). Inputs change 1 ns after
// each rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_rotate_tile_buf;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 6;
  localparam int NCH    = 3;
  localparam int NRD    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  wr_valid;
  logic [NCH-1:0]        wr_en;
  logic [NCH*PIX_W-1:0]  wr_pix;
  logic [NCH*ADDR_W-1:0] wr_addr;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  rd_valid_in;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic                  rd_done;
  logic                  rd_avail;
  logic                  rd_valid;
  logic [NRD*PIX_W-1:0]  wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rotate_tile_buf #(
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .NCH   (NCH),
    .NRD   (NRD)
  ) dut (
    .I_HCLK    (clk),
    .I_HRESET_N(rst_n),
    .I_WR_VALID(wr_valid),
    .I_WR_EN   (wr_en),
    .I_WR_PIX  (wr_pix),
    .I_WR_ADDR (wr_addr),
    .I_WR_LAST (wr_last),
    .O_WR_READY(wr_ready),
    .I_RD_VALID(rd_valid_in),
    .I_RD_ADDR (rd_addr),
    .I_RD_DONE (rd_done),
    .O_RD_AVAIL(rd_avail),
    .O_RD_VALID(rd_valid),
    .O_WDATA   (wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_addr(input logic [5:0] a0, input logic [5:0] a1,
                             input logic [5:0] a2, input logic [5:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  // One read request for a single cycle; returns after the request edge.
  task automatic rd_req(input logic [5:0] a0, input logic [5:0] a1,
                        input logic [5:0] a2, input logic [5:0] a3);
    set_rd_addr(a0, a1, a2, a3);
    rd_valid_in = 1'b1;
    tick();
    rd_valid_in = 1'b0;
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  // Full tile: addr i <- base + i, three addresses per beat, LAST on beat 21.
  task automatic write_tile(input logic [7:0] base);
    for (int b = 0; b < 22; b++) begin
      wr_valid = 1'b1;
      wr_en    = '0;
      for (int c = 0; c < NCH; c++) begin
        int a;
        a = b * 3 + c;
        if (a < 64) begin
          wr_en[c] = 1'b1;
          wr_addr[c*ADDR_W +: ADDR_W] = 6'(a);
          wr_pix[c*PIX_W +: PIX_W]    = base + 8'(a);
        end
      end
      wr_last = (b == 21);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_en    = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    n_checks++;
    if (rd_avail !== 1'b0) begin n_fail++; $display("FAIL reset_rd_avail: got %b expected 0", rd_avail); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++;
    if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", wdata); end
  endtask

  task automatic test_tile0();
    write_tile(8'h00);
    n_checks++;
    if (rd_avail !== 1'b1) begin n_fail++; $display("FAIL tile0_avail: got %b expected 1", rd_avail); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL tile0_wr_ready: got %b expected 1", wr_ready); end
    rd_req(6'd0, 6'd1, 6'd2, 6'd3);
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL tile0_latency_n1: got %b expected 0", rd_valid); end
    tick();
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL tile0_rd_valid: got %b expected 1", rd_valid); end
    n_checks++;
    if (wdata !== 32'h00010203) begin n_fail++; $display("FAIL tile0_wdata: got %h expected 00010203", wdata); end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL tile0_valid_drop: got %b expected 0", rd_valid); end
    n_checks++;
    if (wdata !== 32'h00010203) begin n_fail++; $display("FAIL tile0_wdata_hold: got %h expected 00010203", wdata); end
  endtask

  task automatic test_back_to_back();
    set_rd_addr(6'd63, 6'd62, 6'd0, 6'd10);
    rd_valid_in = 1'b1;
    tick();
    set_rd_addr(6'd7, 6'd7, 6'd40, 6'd33);
    tick();
    rd_valid_in = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || wdata !== 32'h3F3E000A) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=3f3e000a", rd_valid, wdata);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || wdata !== 32'h07072821) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b data=%h expected valid=1 data=07072821", rd_valid, wdata);
    end
    pulse_done();
    n_checks++;
    if (rd_avail !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_release: got avail=%b ready=%b expected avail=0 ready=1", rd_avail, wr_ready);
    end
  endtask

  // Bank 1 now owns the writer.
  task automatic test_collision();
    wr_valid = 1'b1;
    wr_en    = 3'b111;
    wr_addr  = {6'd5, 6'd5, 6'd5};
    wr_pix   = {8'h33, 8'h22, 8'h11};
    wr_last  = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_en    = '0;
    n_checks++;
    if (rd_avail !== 1'b1) begin n_fail++; $display("FAIL coll_avail: got %b expected 1", rd_avail); end
    rd_req(6'd5, 6'd5, 6'd5, 6'd5);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || wdata !== 32'h33333333) begin
      n_fail++; $display("FAIL coll_wdata: got valid=%b data=%h expected valid=1 data=33333333", rd_valid, wdata);
    end
    pulse_done();
  endtask

  // Both banks empty, both pointers back on bank 0.
  task automatic test_backpressure();
    write_tile(8'h00);
    write_tile(8'h80);
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_wr_ready: got %b expected 0", wr_ready); end
    // Beat offered while the writer is blocked must not land anywhere.
    wr_valid = 1'b1;
    wr_en    = 3'b111;
    wr_addr  = {6'd2, 6'd1, 6'd0};
    wr_pix   = {8'hEE, 8'hEE, 8'hEE};
    wr_last  = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_en    = '0;
    n_checks++;
    if (wr_ready !== 1'b0 || rd_avail !== 1'b1) begin
      n_fail++; $display("FAIL bp_blocked: got ready=%b avail=%b expected ready=0 avail=1", wr_ready, rd_avail);
    end
    rd_req(6'd0, 6'd1, 6'd2, 6'd3);
    tick();
    n_checks++;
    if (wdata !== 32'h00010203) begin n_fail++; $display("FAIL bp_not_written: got %h expected 00010203", wdata); end
  endtask

  task automatic test_release_overlap();
    set_rd_addr(6'd0, 6'd1, 6'd2, 6'd3);
    rd_valid_in = 1'b1;
    rd_done     = 1'b1;
    tick();
    rd_valid_in = 1'b0;
    rd_done     = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b1 || rd_avail !== 1'b1) begin
      n_fail++; $display("FAIL ovl_flags: got ready=%b avail=%b expected ready=1 avail=1", wr_ready, rd_avail);
    end
    // Overwrite bank 0 addrs 0..3 while the released read is in flight.
    wr_valid = 1'b1;
    wr_en    = 3'b111;
    wr_addr  = {6'd2, 6'd1, 6'd0};
    wr_pix   = {8'hFF, 8'hFF, 8'hFF};
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || wdata !== 32'h00010203) begin
      n_fail++; $display("FAIL ovl_old_data: got valid=%b data=%h expected valid=1 data=00010203", rd_valid, wdata);
    end
    wr_en   = 3'b001;
    wr_addr = {6'd0, 6'd0, 6'd3};
    wr_last = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_en    = '0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ovl_refull: got %b expected 0", wr_ready); end
    rd_req(6'd0, 6'd1, 6'd2, 6'd63);
    tick();
    n_checks++;
    if (wdata !== 32'h808182BF) begin n_fail++; $display("FAIL ovl_bank1: got %h expected 808182bf", wdata); end
    pulse_done();
    n_checks++;
    if (wr_ready !== 1'b1 || rd_avail !== 1'b1) begin
      n_fail++; $display("FAIL ovl_swap: got ready=%b avail=%b expected ready=1 avail=1", wr_ready, rd_avail);
    end
    rd_req(6'd0, 6'd1, 6'd2, 6'd3);
    tick();
    n_checks++;
    if (wdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ovl_new_data: got %h expected ffffffff", wdata); end
    pulse_done();
  endtask

  // No tile readable: requests and releases must be ignored.
  task automatic test_drop();
    n_checks++;
    if (rd_avail !== 1'b0) begin n_fail++; $display("FAIL drop_avail: got %b expected 0", rd_avail); end
    rd_req(6'd9, 6'd9, 6'd9, 6'd9);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drop_rd_valid: got %b expected 0 (cycle %0d)", rd_valid, i); end
      tick();
    end
    n_checks++;
    if (wdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL drop_wdata_hold: got %h expected ffffffff", wdata); end
    pulse_done();
    n_checks++;
    if (wr_ready !== 1'b1 || rd_avail !== 1'b0) begin
      n_fail++; $display("FAIL drop_done_ignored: got ready=%b avail=%b expected ready=1 avail=0", wr_ready, rd_avail);
    end
  endtask

  task automatic test_reset_mid_read();
    wr_valid = 1'b1;
    wr_en    = 3'b001;
    wr_addr  = '0;
    wr_pix   = {8'h00, 8'h00, 8'h5A};
    wr_last  = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_en    = '0;
    n_checks++;
    if (rd_avail !== 1'b1) begin n_fail++; $display("FAIL rst_mid_avail: got %b expected 1", rd_avail); end
    rd_req(6'd0, 6'd0, 6'd0, 6'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_valid: got %b expected 0 (cycle %0d)", rd_valid, i); end
      tick();
    end
    n_checks++;
    if (rd_avail !== 1'b0 || wr_ready !== 1'b1 || wdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_state: got avail=%b ready=%b data=%h expected avail=0 ready=1 data=00000000",
                         rd_avail, wr_ready, wdata);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_valid    = 1'b0;
    wr_en       = '0;
    wr_pix      = '0;
    wr_addr     = '0;
    wr_last     = 1'b0;
    rd_valid_in = 1'b0;
    rd_addr     = '0;
    rd_done     = 1'b0;

    test_reset();
    test_tile0();
    test_back_to_back();
    test_collision();
    test_backpressure();
    test_release_overlap();
    test_drop();
    test_reset_mid_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
